// File: rtl/lc3_pkg.sv
// Shared encodings for the LC-3 MAR address generator: source modes and
// controller states.
package lc3_pkg;

  typedef enum logic [1:0] {
    MODE_IMM    = 2'b00,
    MODE_OFFSET = 2'b01,
    MODE_IND    = 2'b10,
    MODE_RSVD   = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_IND_REQ  = 2'b01,
    ST_IND_WAIT = 2'b10
  } state_e;

endpackage

// File: rtl/lc3_ext.sv
// Combinational immediate extender: widens IN_W bits to OUT_W bits, either
// sign-extending (SIGNED=1) or zero-extending (SIGNED=0).
module lc3_ext #(
  parameter int IN_W   = 8,
  parameter int OUT_W  = 16,
  parameter int SIGNED = 1
) (
  input  logic [IN_W-1:0]  i_in,
  output logic [OUT_W-1:0] o_out
);

  if (SIGNED != 0) begin : g_sext
    logic signed [IN_W-1:0] w_in_s;
    assign w_in_s = i_in;
    // Size cast of a signed operand replicates the sign bit.
    assign o_out  = OUT_W'(w_in_s);
  end else begin : g_zext
    assign o_out = OUT_W'(i_in);
  end

endmodule

// File: rtl/lc3_addr_gen.sv
// LC-3 MAR address generator: loads MAR from an extended immediate, a
// precomputed offset address, or a pointer fetched from memory.
import lc3_pkg::*;

module lc3_addr_gen #(
  parameter int ADDR_W   = 16,
  parameter int IMM_W    = 8,
  parameter int SEXT_IMM = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [1:0]        i_mode,
  input  logic [IMM_W-1:0]  i_imm,
  input  logic [ADDR_W-1:0] i_offset_addr,
  input  logic              i_abort,
  output logic              o_mem_req,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic              i_mem_rdy,
  input  logic              i_mem_rvalid,
  input  logic [ADDR_W-1:0] i_mem_rdata,
  output logic [ADDR_W-1:0] o_mar,
  output logic              o_mar_valid,
  output logic              o_busy,
  output logic              o_err
);

  state_e            r_state;
  logic [ADDR_W-1:0] r_mar;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_mem_req;
  logic              r_mar_valid;
  logic              r_err;
  logic [ADDR_W-1:0] w_imm_ext;

  lc3_ext #(
    .IN_W  (IMM_W),
    .OUT_W (ADDR_W),
    .SIGNED(SEXT_IMM)
  ) u_ext (
    .i_in (i_imm),
    .o_out(w_imm_ext)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_mar       <= '0;
      r_mem_addr  <= '0;
      r_mem_req   <= 1'b0;
      r_mar_valid <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_mar_valid <= 1'b0;
      r_err       <= 1'b0;
      // Abort outranks start in IDLE and rvalid in IND_WAIT.
      if (i_abort) begin
        r_state   <= ST_IDLE;
        r_mem_req <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (i_start) begin
              case (i_mode)
                MODE_IMM: begin
                  r_mar       <= w_imm_ext;
                  r_mar_valid <= 1'b1;
                end
                MODE_OFFSET: begin
                  r_mar       <= i_offset_addr;
                  r_mar_valid <= 1'b1;
                end
                MODE_IND: begin
                  r_mem_addr <= i_offset_addr;
                  r_mem_req  <= 1'b1;
                  r_state    <= ST_IND_REQ;
                end
                default: r_err <= 1'b1;
              endcase
            end
          end
          ST_IND_REQ: begin
            // rvalid is deliberately not looked at here, even on the accept cycle.
            if (i_mem_rdy) begin
              r_mem_req <= 1'b0;
              r_state   <= ST_IND_WAIT;
            end
          end
          ST_IND_WAIT: begin
            if (i_mem_rvalid) begin
              r_mar       <= i_mem_rdata;
              r_mar_valid <= 1'b1;
              r_state     <= ST_IDLE;
            end
          end
          default: begin
            r_state   <= ST_IDLE;
            r_mem_req <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_mem_req   = r_mem_req;
  assign o_mem_addr  = r_mem_addr;
  assign o_mar       = r_mar;
  assign o_mar_valid = r_mar_valid;
  assign o_err       = r_err;
  assign o_busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_lc3_addr_gen.sv
// Randomized bench for lc3_addr_gen: a sign-extending and a zero-extending
// instance share stimulus and are compared against a transaction-level model.
module tb_lc3_addr_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  mode;
  logic [7:0]  imm;
  logic [15:0] offs;
  logic        abort;
  logic        rdy;
  logic        rvalid;
  logic [15:0] rdata;

  logic        s_req, s_vld, s_busy, s_err;
  logic [15:0] s_addr, s_mar;
  logic        z_req, z_vld, z_busy, z_err;
  logic [15:0] z_addr, z_mar;

  int n_checks = 0;
  int n_errs   = 0;

  logic [15:0] m_mar_s, m_mar_z, m_addr;

  always #5 clk = ~clk;

  lc3_addr_gen #(.ADDR_W(16), .IMM_W(8), .SEXT_IMM(1)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_mode(mode), .i_imm(imm),
    .i_offset_addr(offs), .i_abort(abort), .o_mem_req(s_req), .o_mem_addr(s_addr),
    .i_mem_rdy(rdy), .i_mem_rvalid(rvalid), .i_mem_rdata(rdata), .o_mar(s_mar),
    .o_mar_valid(s_vld), .o_busy(s_busy), .o_err(s_err)
  );

  lc3_addr_gen #(.ADDR_W(16), .IMM_W(8), .SEXT_IMM(0)) u_dut_z (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_mode(mode), .i_imm(imm),
    .i_offset_addr(offs), .i_abort(abort), .o_mem_req(z_req), .o_mem_addr(z_addr),
    .i_mem_rdy(rdy), .i_mem_rvalid(rvalid), .i_mem_rdata(rdata), .o_mar(z_mar),
    .o_mar_valid(z_vld), .o_busy(z_busy), .o_err(z_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Extension from the arithmetic meaning: a negative 8-bit value v-256
  // represented modulo 2^16.
  function automatic logic [15:0] ext_ref(input int v, input bit sgn);
    if (sgn && v >= 128) return 16'(v - 256 + 65536);
    return 16'(v);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input bit req, input bit busy,
                           input bit vld, input bit err);
    chk({tag, ".req"},    32'(s_req),  32'(req));
    chk({tag, ".busy"},   32'(s_busy), 32'(busy));
    chk({tag, ".vld"},    32'(s_vld),  32'(vld));
    chk({tag, ".err"},    32'(s_err),  32'(err));
    chk({tag, ".mar"},    32'(s_mar),  32'(m_mar_s));
    chk({tag, ".addr"},   32'(s_addr), 32'(m_addr));
    chk({tag, ".z_vld"},  32'(z_vld),  32'(vld));
    chk({tag, ".z_busy"}, 32'(z_busy), 32'(busy));
    chk({tag, ".z_mar"},  32'(z_mar),  32'(m_mar_z));
  endtask

  task automatic do_simple(input logic [1:0] md, input logic [7:0] iv, input logic [15:0] ov);
    start = 1'b1; mode = md; imm = iv; offs = ov;
    tick();
    start = 1'b0;
    case (md)
      2'b00: begin
        m_mar_s = ext_ref(int'(iv), 1'b1);
        m_mar_z = ext_ref(int'(iv), 1'b0);
        chk_state("imm", 0, 0, 1, 0);
      end
      2'b01: begin
        m_mar_s = ov;
        m_mar_z = ov;
        chk_state("offset", 0, 0, 1, 0);
      end
      default: chk_state("rsvd", 0, 0, 0, 1);
    endcase
    tick();
    chk_state("simple_idle", 0, 0, 0, 0);
  endtask

  // ab: 0 none, 1 abort while requesting, 2 abort together with rvalid.
  task automatic do_ind(input logic [15:0] ov, input int dly, input int wt,
                        input logic [15:0] rd, input int ab);
    start = 1'b1; mode = 2'b10; offs = ov;
    tick();
    start = 1'b0;
    m_addr = ov;
    chk_state("ind_req", 1, 1, 0, 0);
    for (int i = 0; i < dly; i++) begin
      start = 1'b1; mode = 2'($urandom_range(0, 3)); imm = 8'($urandom);
      offs = 16'($urandom); rvalid = 1'b1; rdata = 16'($urandom);
      tick();
      start = 1'b0; rvalid = 1'b0;
      chk_state("ind_hold", 1, 1, 0, 0);
    end
    if (ab == 1) begin
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk_state("ind_abort_req", 0, 0, 0, 0);
      return;
    end
    rdy = 1'b1; rvalid = 1'b1; rdata = ~rd;
    tick();
    rdy = 1'b0; rvalid = 1'b0;
    chk_state("ind_accept", 0, 1, 0, 0);
    for (int i = 0; i < wt; i++) begin
      start = 1'b1; mode = 2'b00; imm = 8'($urandom);
      tick();
      start = 1'b0;
      chk_state("ind_wait", 0, 1, 0, 0);
    end
    rvalid = 1'b1; rdata = rd; abort = (ab == 2);
    tick();
    rvalid = 1'b0; abort = 1'b0;
    if (ab == 2) begin
      chk_state("ind_abort_wait", 0, 0, 0, 0);
    end else begin
      m_mar_s = rd;
      m_mar_z = rd;
      chk_state("ind_done", 0, 0, 1, 0);
    end
    tick();
    chk_state("ind_idle", 0, 0, 0, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; mode = 2'b00; imm = '0; offs = '0;
    abort = 1'b0; rdy = 1'b0; rvalid = 1'b0; rdata = '0;
    m_mar_s = '0; m_mar_z = '0; m_addr = '0;
    repeat (3) tick();
    chk_state("reset", 0, 0, 0, 0);
    rst_n = 1'b1;
    tick();
    chk_state("post_reset", 0, 0, 0, 0);

    do_simple(2'b00, 8'h80, 16'h0);
    chk("sext_80", 32'(s_mar), 32'h0000FF80);
    chk("zext_80", 32'(z_mar), 32'h00000080);
    do_simple(2'b00, 8'h25, 16'h0);
    chk("zext_25", 32'(z_mar), 32'h00000025);
    do_simple(2'b01, 8'h00, 16'hBEEF);
    do_simple(2'b11, 8'h11, 16'h1234);

    do_ind(16'h3000, 2, 0, 16'h4123, 0);
    chk("ind_4123", 32'(s_mar), 32'h00004123);
    chk("ind_addr_3000", 32'(s_addr), 32'h00003000);
    do_ind(16'h5555, 1, 1, 16'h7777, 2);
    chk("abort_wait_mar", 32'(s_mar), 32'h00004123);
    do_ind(16'h1111, 0, 0, 16'h2222, 1);

    // Abort and start together in IDLE: abort wins.
    start = 1'b1; abort = 1'b1; mode = 2'b01; offs = 16'hCAFE;
    tick();
    start = 1'b0; abort = 1'b0;
    chk_state("abort_start", 0, 0, 0, 0);

    // Reset pulsed while requesting drops everything without a clock edge.
    start = 1'b1; mode = 2'b10; offs = 16'h6000;
    tick();
    start = 1'b0;
    m_addr = 16'h6000;
    chk_state("pre_rst", 1, 1, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    m_mar_s = '0; m_mar_z = '0; m_addr = '0;
    chk_state("async_rst", 0, 0, 0, 0);
    tick();
    rst_n = 1'b1; rvalid = 1'b1; rdata = 16'hDEAD;
    tick();
    rvalid = 1'b0;
    chk_state("late_rvalid", 0, 0, 0, 0);

    for (int n = 0; n < 60; n++) begin
      int md;
      int sel;
      md = int'($urandom_range(0, 3));
      if (md == 2) begin
        sel = int'($urandom_range(0, 5));
        do_ind(16'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
               16'($urandom), (sel < 2) ? sel + 1 : 0);
      end else begin
        do_simple(2'(md), 8'($urandom), 16'($urandom));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
